pipe_share_sched: RTL
=====================

Name: pipe_share_sched

Overview:
- Round-robin scheduler that shares one fixed-latency delay pipeline among NUM_REQ requesters.
- Accepts one beat per cycle from the selected requester and tags it with the requester ID.
- Pushes the beat through a LATENCY-stage register chain and returns it to the originating requester with a one-cycle response strobe.
- Contains an enable-driven IDLE/RUN/DRAIN state machine so the pipeline drains cleanly before going idle; it sits in front of the edge-detect/delay datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, beat data width
LATENCY, 4, pipeline depth in cycles (1..16)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
enable  input  1  permits new grants; low requests a drain
req_valid  input  NUM_REQ  per-requester beat available
req_data  input  NUM_REQ*DATA_W  packed beats, requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant, combinational
rsp_valid  output  NUM_REQ  one-hot response strobe, registered
rsp_data  output  DATA_W  returned beat, registered
in_flight  output  $clog2(LATENCY+1)  beats currently in pipeline
state  output  2  0 = IDLE, 1 = RUN, 2 = DRAIN

Behaviour:
- Reset is clk and rst only: rst==0 sampled at a rising edge. Reset values:
  - state = IDLE, round-robin pointer = 0, all stage valids = 0.
  - in_flight = 0, rsp_valid = 0, rsp_data = 0.
- FSM transitions:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> RUN when enable=1, even if in_flight > 0.
  - DRAIN -> IDLE when enable=0 and in_flight==0, including the in_flight value after the current edge.
  - DRAIN -> IDLE also holds when the pipeline is already empty: one DRAIN cycle minimum.
- Grant rule:
  - Only in RUN is req_ready nonzero.
  - req_ready[i]=1 for the first i with req_valid[i]=1, searching from pointer upward and wrapping modulo NUM_REQ.
  - At most one bit is set.
  - req_ready does not depend on req_ready feedback; no combinational loop through req_valid to itself is allowed.
- Transfer and pointer:
  - A transfer occurs on an edge where req_valid[i] & req_ready[i].
  - After a transfer from i, pointer <= (i+1) mod NUM_REQ.
  - With no transfer, the pointer holds.
- Pipeline:
  - Stage 0 captures {valid, id, data} of the transfer; stage 0 valid = 0 when there is no transfer.
  - Stages shift every cycle unconditionally; there is no stall and no output backpressure.
- Latency:
  - A beat accepted at edge k drives rsp_valid[id]=1 and rsp_data=data between edge k+LATENCY and edge k+LATENCY+1.
  - This holds exactly LATENCY cycles after acceptance, every beat, back-to-back.
- Response idle value:
  - rsp_valid = 0 in cycles without a returning beat.
  - rsp_data holds its last value during those cycles (no zeroing).
- in_flight accounting:
  - in_flight = count of valid stages.
  - It increments on accept and decrements on retire.
  - A simultaneous accept and retire leaves it unchanged.
  - It never exceeds LATENCY.
- enable falls mid-stream:
  - Beats already accepted still complete with normal latency.
  - No beat is lost or duplicated.
- Reset mid-operation:
  - All in-flight beats are discarded.
  - No rsp_valid is asserted in the cycles after reset releases.
- Requester behaviour:
  - A requester dropping req_valid without being granted is legal; nothing is recorded.
  - Requesters must hold req_data stable while req_valid=1 and ungranted.

Decomposition:
- Package pipe_share_pkg holds:
  - typedef sched_state_e {IDLE, RUN, DRAIN}.
  - typedef pipe_stage_t {valid, id, data}, parameterised via localparams matching the defaults.
  - localparam ID_W = $clog2(NUM_REQ).
- Sub-module rr_arbiter (NUM_REQ) holds the pointer register and the combinational grant from req_valid/pointer/grant_en.
- The scheduler instantiates rr_arbiter and owns the FSM, stage array and in_flight counter.

Test Plan:
1. Reset and idle: rst=0 for 2 cycles, then enable=1 with req_valid=4'b0000 -> state 0 then 1, req_ready=0, rsp_valid=0, in_flight=0.
2. Single beat: req_valid=4'b0100 with req_data[2]=32'hDEADBEEF, accepted at edge k -> rsp_valid=4'b0100 and rsp_data=32'hDEADBEEF exactly 4 edges later, for one cycle.
3. Fairness, all four requesting continuously: grants go 0,1,2,3,0,... and responses return in the same order 4 cycles later; in_flight saturates at 4.
4. Drain: enable=0 with 3 beats in flight -> state=2, req_ready=0, all 3 responses arrive, then state=0 the cycle in_flight reaches 0.
5. Drain abort: enable low 1 cycle then high -> DRAIN->RUN, granting resumes at the saved pointer, no beat lost.
6. Reset mid-stream: rst=0 with in_flight=3 -> after release, no rsp_valid for 6 cycles and pointer restarts at requester 0.

Source files
------------

// File: rtl/pipe_share_pkg.sv
// Shared types for the pipe_share_sched slice: scheduler states and the
// default-width pipeline stage record.
package pipe_share_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int ID_W        = $clog2(NUM_REQ_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic                  valid;
        logic [ID_W-1:0]       id;
        logic [DATA_W_DEF-1:0] data;
    } pipe_stage_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from a
// registered pointer, which advances past each granted requester.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       grant_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] ptr;
    logic           found;
    int             idx;

    // Grant depends only on req_valid, ptr and grant_en, so there is no loop.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (grant_en && !found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            ptr <= '0;
        else if (|grant)
            ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + IDW'(1);
    end
endmodule

// File: rtl/pipe_share_sched.sv
// Shares one fixed-latency register pipeline among NUM_REQ requesters,
// tagging beats with their requester id and returning them LATENCY cycles later.
module pipe_share_sched
    import pipe_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]            rsp_data,
    output logic [$clog2(LATENCY+1)-1:0] in_flight,
    output logic [1:0]                   state
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(LATENCY + 1);

    typedef struct packed {
        logic              valid;
        logic [IDW-1:0]    id;
        logic [DATA_W-1:0] data;
    } stage_t;

    sched_state_e   st;
    stage_t         stg [LATENCY];
    logic [IDW-1:0] gnt_id;
    logic [DATA_W-1:0] beat;
    logic           xfer;
    logic           retire;
    logic [CW-1:0]  in_flight_nxt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .grant_en  (st == RUN),
        .req_valid (req_valid),
        .grant     (req_ready),
        .grant_id  (gnt_id)
    );

    // A grant is only ever raised on a valid requester, so any grant is a transfer.
    assign xfer          = |req_ready;
    assign retire        = stg[LATENCY-1].valid;
    assign beat          = req_data[int'(gnt_id)*DATA_W +: DATA_W];
    assign in_flight_nxt = in_flight + CW'(xfer) - CW'(retire);
    assign state         = st;

    // DRAIN looks at the post-edge count so IDLE lands the same edge the pipe empties.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st <= IDLE;
        end else begin
            case (st)
                IDLE:    if (enable) st <= RUN;
                RUN:     if (!enable) st <= DRAIN;
                DRAIN: begin
                    if (enable)                    st <= RUN;
                    else if (in_flight_nxt == '0)  st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < LATENCY; j++) stg[j] <= '0;
            in_flight <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            stg[0].valid <= xfer;
            stg[0].id    <= gnt_id;
            stg[0].data  <= beat;
            for (int j = 1; j < LATENCY; j++) stg[j] <= stg[j-1];
            in_flight <= in_flight_nxt;
            rsp_valid <= '0;
            // rsp_data deliberately holds between returning beats.
            if (retire) begin
                rsp_valid[stg[LATENCY-1].id] <= 1'b1;
                rsp_data                     <= stg[LATENCY-1].data;
            end
        end
    end
endmodule
